// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential 32x32 signed radix-2 Booth multiplier, one iteration per clock
module cla_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    s = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] hi, lo, m_reg, b_op, sum, sum_sel, hi_n, lo_n;
  logic [CW-1:0] count;
  logic q_m1, add, sub, sign, start, done, c1, c2, c3, c4;
  assign add = lo[0] ^ q_m1;
  assign sub = lo[0] & ~q_m1;
  assign b_op = sub ? ~m_reg : m_reg;
  cla_8 u_cla0 (.a(hi[7:0]),   .b(b_op[7:0]),   .cin(sub), .s(sum[7:0]),   .cout(c1));
  cla_8 u_cla1 (.a(hi[15:8]),  .b(b_op[15:8]),  .cin(c1),  .s(sum[15:8]),  .cout(c2));
  cla_8 u_cla2 (.a(hi[23:16]), .b(b_op[23:16]), .cin(c2),  .s(sum[23:16]), .cout(c3));
  cla_8 u_cla3 (.a(hi[31:24]), .b(b_op[31:24]), .cin(c3),  .s(sum[31:24]), .cout(c4));
  // 33rd sum bit of the sign-extended operands; equals sum[31] ^ top-slice overflow
  assign sign = add ? hi[WIDTH-1] ^ b_op[WIDTH-1] ^ c4 : hi[WIDTH-1];
  assign sum_sel = add ? sum : hi;
  assign hi_n = {sign, sum_sel[WIDTH-1:1]};
  assign lo_n = {sum_sel[0], lo[WIDTH-1:1]};
  always_ff @(posedge clock)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    start = (state == IDLE) && ctrl_MULT;
    done = (state == RUN) && (count == LAST);
    state_n = start ? RUN : done ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
      q_m1 <= 1'b0;
      m_reg <= '0;
      count <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy <= 1'b0;
    end else begin
      data_resultRDY <= done;
      if (start) begin
        hi <= '0;
        lo <= data_operandB;
        q_m1 <= 1'b0;
        m_reg <= data_operandA;
        count <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        hi <= hi_n;
        lo <= lo_n;
        q_m1 <= lo[0];
        count <= count + 1'b1;
        if (done) begin
          data_result <= lo_n;
          data_exception <= hi_n != {WIDTH{lo_n[WIDTH-1]}};
          busy <= 1'b0;
        end
      end
    end
  end
endmodule
